i2c_target_rx: RTL

Write-only I2C target (slave) receiver; the downstream consumer of the team's I2C master transmitter.
- Oversamples SCL/SDA on a faster system clock.
- Detects START/STOP, shifts in the 7-bit address and R/W bit, and ACKs a matching write.
- Shifts in data bytes and presents each one as a single-cycle valid pulse to on-chip logic.
- SDA drive is open-drain style: the block only ever pulls the line low.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 55 +++++
 rtl/i2c_target_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master transmitter and target receiver.
// Holds the receiver state encoding, the R/W bit values and the bit
// counter reload value.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } i2c_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    // Bytes are shifted MSB first; the counter starts at bit 7.
    localparam logic [2:0] BIT_CNT_MSB = 3'd7;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizer and bus-event detector for SCL/SDA.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   i2c_scl, i2c_sda     raw bus pins, asynchronous to clk
//   scl_rise, scl_fall   one-cycle SCL edge strobes
//   start_det, stop_det  one-cycle START / STOP strobes
//   sda_s                synchronized SDA
// All registers reset to 1 so an idle bus produces no edge after reset.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i2c_scl,
    input  logic i2c_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_q;
    logic                   r_sda_q;
    logic                   w_scl_s;
    logic                   w_sda_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sda};
            r_scl_q    <= w_scl_s;
            r_sda_q    <= w_sda_s;
        end
    end

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

    assign scl_rise = w_scl_s & ~r_scl_q;
    assign scl_fall = ~w_scl_s & r_scl_q;
    // Requiring SCL high in both samples suppresses START/STOP when SCL and
    // SDA move in the same cycle.
    assign start_det = w_scl_s & r_scl_q & r_sda_q & ~w_sda_s;
    assign stop_det  = w_scl_s & r_scl_q & ~r_sda_q & w_sda_s;
    assign sda_s     = w_sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver.
// Ports:
//   clk, reset          system clock (>= 8x SCL), synchronous active-high reset
//   i2c_scl, i2c_sda    bus pins (SDA as seen on the wire)
//   sda_oe              1 = pull SDA low (ACK), 0 = release
//   addr_match          pulse when address == DEV_ADDR with a write
//   rx_data, rx_valid   last received byte and its one-cycle update strobe
//   stop_seen           pulse on STOP
//   busy                high whenever the FSM is not IDLE
//   dbg_state           current FSM state (i2c_state_t encoding)
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       sda_oe,
    output logic       addr_match,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       stop_seen,
    output logic       busy,
    output logic [2:0] dbg_state
);

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .clk       (clk),
        .reset     (reset),
        .i2c_scl   (i2c_scl),
        .i2c_sda   (i2c_sda),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda_s)
    );

    i2c_state_t r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [6:0] r_shift, w_shift_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_addr_match, w_addr_match_nxt;
    logic       r_stop_seen, w_stop_seen_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic [7:0] w_byte;

    // The byte as it stands once the bit now on SDA is shifted in.
    assign w_byte = {r_shift, w_sda_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_shift      <= 7'd0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_addr_match <= 1'b0;
            r_stop_seen  <= 1'b0;
            r_sda_oe     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_addr_match <= w_addr_match_nxt;
            r_stop_seen  <= w_stop_seen_nxt;
            r_sda_oe     <= w_sda_oe_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = 1'b0;
        w_addr_match_nxt = 1'b0;
        w_stop_seen_nxt  = 1'b0;
        w_sda_oe_nxt     = r_sda_oe;

        // START/STOP override everything and drop any partial byte.
        if (w_stop) begin
            w_state_nxt     = IDLE;
            w_sda_oe_nxt    = 1'b0;
            w_stop_seen_nxt = 1'b1;
        end else if (w_start) begin
            w_state_nxt  = ADDR;
            w_cnt_nxt    = BIT_CNT_MSB;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte[6:0];
                        if (r_cnt == 3'd0) begin
                            if (w_byte[7:1] == DEV_ADDR && w_byte[0] == I2C_RW_WRITE)
                                w_state_nxt = ADDR_ACK;
                            else
                                w_state_nxt = IGNORE;
                        end else begin
                            w_cnt_nxt = r_cnt - 3'd1;
                        end
                    end
                end
                // First SCL fall drives the ACK, the second releases it.
                // sda_oe itself tells the two falls apart.
                ADDR_ACK, DATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt     = 1'b1;
                            w_addr_match_nxt = (r_state == ADDR_ACK);
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = BIT_CNT_MSB;
                            w_state_nxt  = DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte[6:0];
                        if (r_cnt == 3'd0) begin
                            w_rx_data_nxt  = w_byte;
                            w_rx_valid_nxt = 1'b1;
                            w_state_nxt    = DATA_ACK;
                        end else begin
                            w_cnt_nxt = r_cnt - 3'd1;
                        end
                    end
                end
                IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_oe     = r_sda_oe;
    assign addr_match = r_addr_match;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign stop_seen  = r_stop_seen;
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule
